// File: rtl/mvm_job_sequencer.sv
// -----------------------------------------------------------------------------
// mvm_job_sequencer
//
// Runs one matrix_vector_multiplier job from start to finish:
//   1. Takes a byte stream from the host or fetcher. The stream carries A in
//      row-major order (DIM*DIM bytes), followed by B (DIM bytes).
//   2. Sends each byte to the matching multiplier FIFO with a one-cycle write
//      strobe. fifo_sel is the A row (0..DIM-1) or DIM for the B FIFO.
//   3. Holds fetch_done high until the multiplier raises mvm_done, then
//      captures all DIM results in a single cycle.
//   4. Sends the results out one at a time. The last one is marked with
//      o_out_last.
//
// Handshakes: data moves on a rising edge only when valid and ready are both
// high in the cycle before it. Once valid is raised it stays high, and its
// data stays stable, until ready is also high. Ready never depends on valid.
//
// Optional feature (compile-time macro MVM_SEQ_TIMEOUT_EN):
//   If mvm_done does not arrive within TIMEOUT_CYCLES cycles in WAIT, the job
//   is abandoned. o_err pulses for one cycle and the sequencer returns to
//   IDLE. Without the macro, WAIT has no time limit and o_err is tied to 0.
//
// Ports:
//   clk, rst_n       clock (rising edge); asynchronous active-low reset
//   i_in_data        A/B element stream          (DATA_WIDTH)
//   i_in_valid       stream valid
//   o_in_ready       stream ready (IDLE and LOAD only)
//   o_fifo_data      multiplier FIFO write data  (DATA_WIDTH)
//   o_fifo_sel       multiplier FIFO select: 0..DIM-1 = A rows, DIM = B
//   o_fifo_wren      one-cycle FIFO write strobe
//   o_fetch_done     load complete; held high through WAIT
//   i_mvm_result     flattened results; element i at [i*3*DW +: 3*DW]
//   i_mvm_done       multiplier finished (used only in WAIT)
//   o_out_data       result element              (3*DATA_WIDTH)
//   o_out_valid      result valid (DRAIN only)
//   i_out_ready      consumer ready
//   o_out_last       marks element DIM-1
//   o_busy           high in every state except IDLE
//   o_err            one-cycle timeout pulse
//   o_dbg_state      current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module mvm_job_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DIM            = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         i_in_data,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [3:0]                    o_fifo_sel,
    output logic                          o_fifo_wren,
    output logic                          o_fetch_done,
    input  logic [DIM*3*DATA_WIDTH-1:0]   i_mvm_result,
    input  logic                          i_mvm_done,
    output logic [3*DATA_WIDTH-1:0]       o_out_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_out_last,
    output logic                          o_busy,
    output logic                          o_err,
    output logic [1:0]                    o_dbg_state
);

    localparam int unsigned RES_W  = 3 * DATA_WIDTH;
    localparam int unsigned NBYTES = DIM * DIM + DIM;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam int unsigned IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [3:0]       B_SEL     = 4'(DIM);
    localparam logic [3:0]       LAST_COL  = 4'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [CNT_W-1:0]        r_byte_cnt;
    logic [3:0]              r_row;
    logic [3:0]              r_col;
    logic [DATA_WIDTH-1:0]   r_fifo_data;
    logic [3:0]              r_fifo_sel;
    logic                    r_fifo_wren;
    logic                    r_fetch_done;
    logic [DIM*RES_W-1:0]    r_cap;
    logic [IDX_W-1:0]        r_out_idx;

    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_busy;
    logic                    w_capture;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_last_byte;
    logic                    w_last_idx;
    logic                    w_timeout;

    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_last_idx  = (r_out_idx == LAST_IDX);
    assign w_in_fire   = i_in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & i_out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                // The first accepted byte is byte 0. A job always has at
                // least two bytes, so this byte is never the last.
                if (i_in_valid) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (i_in_valid && w_last_byte) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mvm_done) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DRAIN;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                if (i_out_ready && w_last_idx) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load path: byte counter, row/column tracking, FIFO write register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_fifo_data <= '0;
            r_fifo_sel  <= '0;
            r_fifo_wren <= 1'b0;
        end else begin
            r_fifo_wren <= w_in_fire;
            if (w_in_fire) begin
                r_fifo_data <= i_in_data;
                // r_row is the A row of this byte. After the last A row it
                // stops at DIM, which is also the B FIFO select, so no
                // divide is needed.
                r_fifo_sel  <= r_row;
                if (w_last_byte) begin
                    r_byte_cnt <= '0;
                    r_row      <= '0;
                    r_col      <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        if (r_row != B_SEL) begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // fetch_done, result capture and drain index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_done <= 1'b0;
            r_cap        <= '0;
            r_out_idx    <= '0;
        end else begin
            // fetch_done rises one cycle after the last FIFO write is seen,
            // and it falls on the edge that leaves WAIT.
            r_fetch_done <= (r_state == S_WAIT) && (w_next_state == S_WAIT);
            if (w_capture) begin
                r_cap     <= i_mvm_result;
                r_out_idx <= '0;
            end else if (w_out_fire) begin
                r_out_idx <= w_last_idx ? '0 : r_out_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------
`ifdef MVM_SEQ_TIMEOUT_EN
    localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_err;

    // The counter is 0 on the first WAIT cycle. When it reaches
    // TIMEOUT_CYCLES-1 with no done, TIMEOUT_CYCLES WAIT cycles have passed,
    // so the job is abandoned on that edge.
    assign w_timeout = (r_state == S_WAIT) && !i_mvm_done && (r_wait_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_in_ready   = w_in_ready;
    assign o_fifo_data  = r_fifo_data;
    assign o_fifo_sel   = r_fifo_sel;
    assign o_fifo_wren  = r_fifo_wren;
    assign o_fetch_done = r_fetch_done;
    assign o_out_valid  = w_out_valid;
    assign o_out_last   = w_out_valid & w_last_idx;
    assign o_out_data   = w_out_valid ? r_cap[r_out_idx*RES_W +: RES_W] : '0;
    assign o_busy       = w_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mvm_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mvm_job_sequencer
//
// Directed sequence of jobs with random data, random input gaps and random
// output backpressure. For each job, the reference model builds the expected
// FIFO write list and the expected result vector with plain loops and
// arithmetic. A small multiplier model sends back those results after a
// fixed latency.
// -----------------------------------------------------------------------------
module tb_mvm_job_sequencer;

    localparam int DW  = 8;
    localparam int DIM = 8;
    localparam int RW  = 3 * DW;
    localparam int NB  = DIM * DIM + DIM;
    localparam int TMO = 16;
`ifdef MVM_SEQ_TIMEOUT_EN
    localparam int MVM_LAT = 10;
`else
    localparam int MVM_LAT = 30;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]      in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      fifo_data;
    logic [3:0]         fifo_sel;
    logic               fifo_wren;
    logic               fetch_done;
    logic [DIM*RW-1:0]  mvm_result;
    logic               mvm_done;
    logic [RW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               err;
    logic [1:0]         dbg_state;

    mvm_job_sequencer #(
        .DATA_WIDTH     (DW),
        .DIM            (DIM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_fifo_data  (fifo_data),
        .o_fifo_sel   (fifo_sel),
        .o_fifo_wren  (fifo_wren),
        .o_fetch_done (fetch_done),
        .i_mvm_result (mvm_result),
        .i_mvm_done   (mvm_done),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_last   (out_last),
        .o_busy       (busy),
        .o_err        (err),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [DW+3:0] exp_q[$];   // expected FIFO writes: {sel, data}
    logic [RW-1:0] res_q[$];   // expected results, element 0 first
    logic [DW-1:0] a_m[DIM][DIM];
    logic [DW-1:0] b_m[DIM];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pat 0: A[i][j]=i+j+1, B[j]=j+1   pat 1: A=1, B=2   pat 2: random
    task automatic build_job(input int pat);
        logic [RW-1:0] acc;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                case (pat)
                    0:       a_m[i][j] = DW'(i + j + 1);
                    1:       a_m[i][j] = 8'd1;
                    default: a_m[i][j] = DW'($urandom_range(0, 255));
                endcase
            end
        end
        for (int j = 0; j < DIM; j++) begin
            case (pat)
                0:       b_m[j] = DW'(j + 1);
                1:       b_m[j] = 8'd2;
                default: b_m[j] = DW'($urandom_range(0, 255));
            endcase
        end
        // Each row of A goes to its own FIFO, then all of B goes to FIFO DIM.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                exp_q.push_back({4'(i), a_m[i][j]});
        for (int j = 0; j < DIM; j++)
            exp_q.push_back({4'(DIM), b_m[j]});
        for (int i = 0; i < DIM; i++) begin
            acc = '0;
            for (int j = 0; j < DIM; j++)
                acc = acc + a_m[i][j] * b_m[j];
            res_q.push_back(acc);
        end
    endtask

    function automatic logic [DW-1:0] byte_at(input int k);
        if (k < DIM * DIM) return a_m[k / DIM][k % DIM];
        return b_m[k - DIM * DIM];
    endfunction

    // ---------------- driver tasks ----------------
    // Each task is entered and left 1 time unit after a rising edge.
    task automatic send_byte(input logic [DW-1:0] d, input int gap);
        logic [DW+3:0] e;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            check("gap_wren", fifo_wren, 0);
        end
        in_valid = 1'b1;
        in_data  = d;
        check("load_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("wren", fifo_wren, 1);
            check("fifo_sel", fifo_sel, e[DW+3:DW]);
            check("fifo_data", fifo_data, e[DW-1:0]);
        end
    endtask

    // gap_mode 0: gapless, 1: one idle cycle between bytes, 2: random 0..2
    task automatic load_job(input int pat, input int gap_mode);
        int gap;
        build_job(pat);
        for (int k = 0; k < NB; k++) begin
            case (gap_mode)
                0:       gap = 0;
                1:       gap = (k == 0) ? 0 : 1;
                default: gap = $urandom_range(0, 2);
            endcase
            send_byte(byte_at(k), gap);
        end
        check("in_ready_drop", in_ready, 0);
        check("fetch_done_not_yet", fetch_done, 0);
        check("busy_load", busy, 1);
    endtask

    task automatic drain();
        logic [RW-1:0] e;
        int  budget;
        bit  taken;
        for (int i = 0; i < DIM; i++) begin
            e      = res_q.pop_front();
            taken  = 1'b0;
            budget = 0;
            while (!taken) begin
                out_ready = ($urandom_range(0, 1) == 1);
                check("out_valid", out_valid, 1);
                check("out_data", out_data, e);
                check("out_last", out_last, (i == DIM - 1) ? 1 : 0);
                taken = out_ready;
                @(posedge clk); #1;
                budget++;
                if (budget > 200) begin
                    check("drain_budget", 0, 1);
                    taken = 1'b1;
                end
            end
        end
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_fetch_done", fetch_done, 0);
    endtask

    task automatic run_job(input int pat, input int gap_mode, input bit hold);
        load_job(pat, gap_mode);
        // The stream keeps valid high during WAIT; the sequencer must ignore it.
        if (hold) in_valid = 1'b1;
        @(posedge clk); #1;
        check("fetch_done_rise", fetch_done, 1);
        for (int c = 1; c < MVM_LAT; c++) begin
            check("wait_fetch_done", fetch_done, 1);
            check("wait_in_ready", in_ready, 0);
            check("wait_wren", fifo_wren, 0);
            check("wait_out_valid", out_valid, 0);
            check("wait_err", err, 0);
            @(posedge clk); #1;
        end
        // Multiplier model: results become valid together with done.
        for (int i = 0; i < DIM; i++) mvm_result[i*RW +: RW] = res_q[i];
        mvm_done = 1'b1;
        @(posedge clk); #1;
        // Change the result bus after capture; done stays high when hold is set.
        for (int i = 0; i < DIM; i++) mvm_result[i*RW +: RW] = RW'($urandom);
        mvm_done = hold;
        in_valid = 1'b0;
        check("fetch_done_fall", fetch_done, 0);
        drain();
        mvm_done = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        in_data    = '0;
        in_valid   = 1'b0;
        mvm_result = '0;
        mvm_done   = 1'b0;
        out_ready  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_wren", fifo_wren, 0);
        check("rst_fetch_done", fetch_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_sel", fifo_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(0, 0, 1'b0);   // gapless, A=i+j+1, B=j+1
        run_job(0, 1, 1'b1);   // valid every other cycle, back to back
        run_job(1, 2, 1'b0);   // A=1, B=2 -> every result 16
        run_job(2, 2, 1'b1);
        run_job(2, 0, 1'b0);

        // Reset partway through LOAD.
        build_job(2);
        for (int k = 0; k < 20; k++) send_byte(byte_at(k), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midload_wren", fifo_wren, 0);
        check("midload_in_ready", in_ready, 1);
        check("midload_busy", busy, 0);
        check("midload_fetch_done", fetch_done, 0);
        check("midload_out_valid", out_valid, 0);
        exp_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during WAIT: fetch_done must drop without waiting for a clock edge.
        load_job(2, 2);
        @(posedge clk); #1;
        check("midwait_fetch_done_hi", fetch_done, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_fetch_done", fetch_done, 0);
        check("midwait_busy", busy, 0);
        check("midwait_in_ready", in_ready, 1);
        res_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(2, 2, 1'b0);   // recovery after reset

`ifdef MVM_SEQ_TIMEOUT_EN
        // No done: err pulses after TMO cycles in WAIT, then IDLE.
        load_job(2, 0);
        for (int c = 1; c <= TMO; c++) begin
            @(posedge clk); #1;
            if (c < TMO) begin
                check("tmo_err_low", err, 0);
                check("tmo_fetch_done", fetch_done, 1);
            end else begin
                check("tmo_err", err, 1);
                check("tmo_fetch_done_fall", fetch_done, 0);
                check("tmo_busy", busy, 0);
                check("tmo_in_ready", in_ready, 1);
                check("tmo_out_valid", out_valid, 0);
            end
        end
        @(posedge clk); #1;
        check("tmo_err_pulse", err, 0);
        res_q.delete();
        run_job(2, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
